// File: rtl/rom_reader_if.sv
// rom_reader_if: bundles the two buses of the ROM read master.
//   - ROM pins: address / read_en / ce driven by the master, data_in returned
//     combinationally by the ROM.
//   - Output stream: out_data / out_valid / out_last with out_ready
//     back-pressure from the consumer.
// master modport = rom_reader side, slave modport = ROM + consumer side.
interface rom_reader_if #(
   parameter int AW = 8,
   parameter int DW = 8
);

   logic [AW-1:0] address;
   logic          read_en;
   logic          ce;
   logic [DW-1:0] data_in;

   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;

   modport master (
      output address,
      output read_en,
      output ce,
      input  data_in,
      output out_data,
      output out_valid,
      input  out_ready,
      output out_last
   );

   modport slave (
      input  address,
      input  read_en,
      input  ce,
      output data_in,
      input  out_data,
      input  out_valid,
      output out_ready,
      input  out_last
   );

endinterface

// File: rtl/rom_reader.sv
// rom_reader: burst read master for a combinational lookup ROM.
// A start command launches a burst of consecutive ROM reads; each returned
// byte lands in a 2-entry buffer and is streamed out with valid/ready and a
// last-beat marker.
//
// Optional feature macro: ROM_READER_CHECKSUM_EN
//   defined   -> checksum_o is the modulo-2^DW sum of every transferred byte,
//                cleared when a burst is accepted.
//   undefined -> checksum_o is tied to zero.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start_i; ROM pins quiet
// S_READ  | issuing reads while beats remain and buffer has room
// S_DRAIN | all reads issued, waiting for the buffer to empty
// S_DONE  | one-cycle done pulse, then back to S_IDLE
module rom_reader #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   rom_reader_if.master    bus,
   input  logic            start_i,
   input  logic [AW-1:0]   start_addr_i,
   input  logic [AW:0]     len_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [DW-1:0]   checksum_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]    state_q,      state_d;
   logic [AW-1:0] address_q,    address_d;
   logic          read_en_q,    read_en_d;
   logic          last_issue_q, last_issue_d;
   logic [AW:0]   remaining_q,  remaining_d;

   logic [DW-1:0] buf_data_q [2];
   logic          buf_last_q [2];
   logic          wr_ptr_q,     wr_ptr_d;
   logic          rd_ptr_q,     rd_ptr_d;
   logic [1:0]    count_q,      count_d;

   logic          push;
   logic          pop;
   logic          buf_valid;

   // A read issued in this cycle is captured at the closing edge, so the
   // registered read strobe doubles as the buffer push.
   assign buf_valid = (count_q != 2'd0);
   assign push      = read_en_q;
   assign pop       = buf_valid & bus.out_ready;

   // Buffer occupancy and pointers after the coming edge.
   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push && !pop) begin
         count_d = count_q + 2'd1;
      end else if (pop && !push) begin
         count_d = count_q - 2'd1;
      end
      if (push) begin
         wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
   end

   // Burst sequencing. The read strobe is registered, so the decision to
   // issue in the next cycle is taken on the occupancy that will exist after
   // this edge: issue only if that leaves a free slot for the new byte, since
   // a pop in the next cycle cannot be known yet.
   always_comb begin
      state_d      = state_q;
      address_d    = address_q;
      read_en_d    = 1'b0;
      last_issue_d = 1'b0;
      remaining_d  = remaining_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (len_i != '0) begin
                  state_d      = S_READ;
                  address_d    = start_addr_i;
                  read_en_d    = 1'b1;
                  last_issue_d = (len_i == (AW+1)'(1));
                  remaining_d  = len_i - (AW+1)'(1);
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_READ: begin
            if (remaining_q != '0) begin
               if (count_d != 2'd2) begin
                  read_en_d    = 1'b1;
                  address_d    = address_q + AW'(1);
                  last_issue_d = (remaining_q == (AW+1)'(1));
                  remaining_d  = remaining_q - (AW+1)'(1);
               end
            end else begin
               // remaining_q hits zero while the final read is on the pins.
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (count_d == 2'd0) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control and ROM-pin registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         address_q    <= '0;
         read_en_q    <= 1'b0;
         last_issue_q <= 1'b0;
         remaining_q  <= '0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         count_q      <= 2'd0;
      end else begin
         state_q      <= state_d;
         address_q    <= address_d;
         read_en_q    <= read_en_d;
         last_issue_q <= last_issue_d;
         remaining_q  <= remaining_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
      end
   end

   // Output buffer storage: capture ROM data and its last-beat tag on push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            buf_data_q[i] <= '0;
            buf_last_q[i] <= 1'b0;
         end
      end else if (push) begin
         buf_data_q[wr_ptr_q] <= bus.data_in;
         buf_last_q[wr_ptr_q] <= last_issue_q;
      end
   end

   assign bus.address   = address_q;
   assign bus.read_en   = read_en_q;
   assign bus.ce        = read_en_q;
   assign bus.out_valid = buf_valid;
   assign bus.out_data  = buf_valid ? buf_data_q[rd_ptr_q] : '0;
   assign bus.out_last  = buf_valid & buf_last_q[rd_ptr_q];

   assign busy_o = (state_q != S_IDLE);
   assign done_o = (state_q == S_DONE);

`ifdef ROM_READER_CHECKSUM_EN
   logic [DW-1:0] checksum_q;

   // Running sum of streamed bytes; restarts when a burst (even empty) is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         checksum_q <= '0;
      end else if ((state_q == S_IDLE) && start_i) begin
         checksum_q <= '0;
      end else if (pop) begin
         checksum_q <= checksum_q + bus.out_data;
      end
   end

   assign checksum_o = checksum_q;
`else
   assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_rom_reader.sv
// tb_rom_reader: directed bench for rom_reader against an identity ROM
// (mem[i] = i). Expected beats go into a scoreboard queue when a burst is
// launched and are popped as the DUT hands them over.
module tb_rom_reader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_i = 1'b0;
   logic [7:0] start_addr_i = '0;
   logic [8:0] len_i = '0;
   logic       busy_o;
   logic       done_o;
   logic [7:0] checksum_o;

   rom_reader_if #(.AW(8), .DW(8)) bus ();

   assign bus.data_in = bus.address;

   rom_reader #(.AW(8), .DW(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .start_i      (start_i),
      .start_addr_i (start_addr_i),
      .len_i        (len_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .checksum_o   (checksum_o)
   );

   always #5 clk = ~clk;

   int         n_asrt = 0;
   int         n_fail = 0;
   logic [8:0] sb [$];
   int         cyc, reads, beats, done_cnt, done_cyc, fv;
   logic [7:0] exp_addr;
   logic [7:0] sum;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: sample at the falling edge, then move past the rising edge.
   task automatic step();
      logic [8:0] e;
      @(negedge clk);
      chk("ce_eq_read_en", bus.ce, bus.read_en);
      if (bus.read_en) begin
         chk("rd_addr", bus.address, exp_addr);
         exp_addr = exp_addr + 8'd1;
         reads++;
      end
      if (bus.out_valid && bus.out_ready) begin
         if (fv < 0) fv = cyc;
         chk("sb_nonempty", (sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("beat_data", bus.out_data, e[7:0]);
            chk("beat_last", bus.out_last, e[8]);
         end
         sum = sum + bus.out_data;
         beats++;
      end
      if (done_o) begin
         done_cnt++;
         if (done_cyc < 0) done_cyc = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"},  busy_o, 0);
      chk({tag, "_done"},  done_o, 0);
      chk({tag, "_valid"}, bus.out_valid, 0);
      chk({tag, "_last"},  bus.out_last, 0);
      chk({tag, "_data"},  bus.out_data, 0);
      chk({tag, "_rden"},  bus.read_en, 0);
      chk({tag, "_ce"},    bus.ce, 0);
      chk({tag, "_addr"},  bus.address, 0);
      chk({tag, "_csum"},  checksum_o, 0);
   endtask

   // Launch a burst and follow it to completion.
   //   stall      : out_ready low for cycles 0..stall (0 = always ready)
   //   poke_cyc   : cycle in which a stray start with a different address is pulsed
   //   abort_beats: assert reset after this many beats (0 = run to end)
   task automatic run_burst(input logic [7:0] addr, input int n, input int stall,
                            input int poke_cyc, input int abort_beats);
      bit         fin = 0;
      bit         aborted = 0;
      logic [7:0] exp_ck;
      for (int i = 0; i < n; i++) begin
         logic [7:0] a;
         a = addr + 8'(i);
         sb.push_back({(i == n - 1) ? 1'b1 : 1'b0, a});
      end
      exp_addr = addr; reads = 0; beats = 0; done_cnt = 0; done_cyc = -1; fv = -1; sum = '0;
      cyc = 0;
      start_i = 1'b1; start_addr_i = addr; len_i = 9'(n);
      bus.out_ready = (stall == 0);
      step();
      for (int k = 0; k < 800 && !fin && !aborted; k++) begin
         bus.out_ready = (cyc > stall);
         if (cyc == poke_cyc) begin
            start_i = 1'b1; start_addr_i = addr ^ 8'h55; len_i = 9'd3;
         end else begin
            start_i = 1'b0;
         end
         if (stall > 0 && cyc == stall) begin
            chk("stall_reads", reads, 2);
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_data", bus.out_data, addr);
         end
         if (abort_beats > 0 && beats == abort_beats) begin
            rst_n = 1'b0;
            #1;
            chk_reset_outputs("midrst");
            sb.delete();
            @(posedge clk); #1;
            chk("midrst_hold_rden", bus.read_en, 0);
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk); #1;
            aborted = 1;
         end else begin
            step();
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
               chk("busy_after_done", busy_o, 0);
               fin = 1;
            end
         end
      end
      start_i = 1'b0;
      if (!aborted) begin
         chk("no_timeout", fin, 1);
         chk("done_pulses", done_cnt, 1);
         chk("sb_drained", sb.size(), 0);
         chk("beats", beats, n);
         chk("reads", reads, n);
         if (stall == 0) chk("done_cyc", done_cyc, (n == 0) ? 1 : n + 2);
         if (stall == 0 && n > 0) chk("first_valid_cyc", fv, 2);
`ifdef ROM_READER_CHECKSUM_EN
         exp_ck = sum;
`else
         exp_ck = 8'h00;
`endif
         chk("checksum", checksum_o, exp_ck);
      end
   endtask

   initial begin
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic 4-beat burst, always ready.
      run_burst(8'h10, 4, 0, 0, 0);
`ifdef ROM_READER_CHECKSUM_EN
      chk("csum_10_13", checksum_o, 8'h46);
`endif
      // Address wrap.
      run_burst(8'hFE, 4, 0, 0, 0);
      // Back-pressure for 10 cycles.
      run_burst(8'h00, 5, 10, 0, 0);
      // Empty burst.
      run_burst(8'h33, 0, 0, 0, 0);
      // Full 256-beat burst.
      run_burst(8'h00, 256, 0, 0, 0);
      // Stray start while busy.
      run_burst(8'h20, 6, 0, 3, 0);
      // Reset in the middle of an 8-beat burst, then a clean burst.
      run_burst(8'h40, 8, 0, 0, 2);
      run_burst(8'h80, 3, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule

// File: doc/rom_reader.md
# rom_reader

Sequential read master for the 8-bit combinational lookup ROM (address / read_en / ce / data). On a start command it drives the ROM's address, read_en and ce pins for a burst of consecutive addresses. It captures each returned byte into a 2-entry output buffer and streams the bytes out on a valid/ready interface with a last-beat marker. It sits between the ROM and downstream consumers (PUF helper-data loader, BCH parameter fetch) so they no longer sequence the ROM pins themselves.

## Interface
- AW, 8, ROM address width; burst length counter is AW+1 bits.
- DW, 8, ROM data width.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  burst request; sampled only in IDLE.
- start_addr  input  AW  first ROM address of the burst.
- len  input  AW+1  beats in burst, 0..256; 0 = empty burst.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse at end of burst.
- address  output  AW  ROM address, registered.
- read_en  output  1  ROM read enable, registered.
- ce  output  1  ROM chip enable; identical to read_en.
- data_in  input  DW  ROM data output, combinational from address.
- out_data  output  DW  head-of-buffer byte.
- out_valid  output  1  buffer non-empty.
- out_ready  input  1  downstream accepts when high with out_valid.
- out_last  output  1  head byte is final beat of burst.
- checksum  output  DW  running sum of streamed bytes (see Configuration).

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE: start=1 and len!=0 -> latch start_addr and len, go to READ. start=1 and len=0 -> go to DONE, no ROM access. start=0 -> stay.
- READ: a ROM read is issued in any cycle where remaining>0 and (buffer count<2 or a pop occurs this cycle).
  - Issue means address=current address, read_en=ce=1, registered.
  - data_in is captured into the buffer at the rising edge that ends the issue cycle.
  - Address increments modulo 2^AW; 0xFF wraps to 0x00.
  - remaining decrements per issue. After the last issue, go to DRAIN.
- DRAIN: no reads; read_en=ce=0. When the buffer is empty after the last-beat handshake, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- A beat transfers when out_valid && out_ready. Push and pop in the same cycle with count=2 is legal, and count stays 2.
- out_last is high with the byte captured from the final issued address.
- start is ignored while busy, and the latched parameters are unaffected.
- When not issuing, read_en=ce=0 and address holds its last value.
- Reset, including mid-burst: state=IDLE; address=0, read_en=ce=0, busy=0, done=0, out_valid=0, out_last=0, out_data=0, checksum=0; buffer flushed, in-flight data discarded.

## Timing
- Cycle 0: start sampled. Cycle 1: first issue (address=start_addr, read_en=ce=1). Cycle 2: out_valid=1 with data of start_addr. Latency from start to first data is 2 cycles.
- With out_ready held high, throughput is 1 byte/cycle with no bubbles.
- N-beat burst with out_ready high: last beat transfers in cycle N+1, done=1 in cycle N+2, busy=0 in cycle N+3.
- Back-pressure: with out_ready low, at most 2 issues occur after the last pop, then read_en stays low until space frees.
- len=0: done=1 in cycle 1, and read_en never asserts.

## Configuration
- ROM_READER_CHECKSUM_EN defined:
  - checksum accumulates the DW-bit modulo-2^DW sum of every transferred out_data.
  - checksum clears to 0 when a burst starts.
  - checksum holds its final value from the cycle after the last beat until the next start.
- Macro undefined: checksum is tied to 0 and no accumulator logic is built.
- All other behaviour is identical in both builds.

## Test plan
- ROM holds mem[i]=i. start_addr=0x10, len=4, out_ready=1 -> out_data 10,11,12,13 in cycles 2–5; out_last only on 13; done in cycle 6; checksum=0x46 when enabled.
- start_addr=0xFE, len=4 -> addresses FE,FF,00,01; data FE,FF,00,01 (wrap).
- out_ready=0 for 10 cycles after start, len=5 -> exactly 2 reads issued and out_valid held with 0x00 (start_addr=0). Then out_ready=1 -> remaining bytes 02,03,04 follow back-to-back with none lost or duplicated.
- len=0 -> done=1 one cycle after start; read_en/ce never 1. len=256 from 0x00 -> 256 beats, out_last on 0xFF.
- start pulsed while busy with different start_addr -> ignored; original burst completes unchanged.
- rst_n low mid-burst (after 2 beats of 8) -> all outputs at reset values immediately; new start after release runs a clean burst from its own start_addr.
